// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: one-hot row drive, frame-based debounce,
// single key code per press delivered through a valid/ack handshake.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  colMeta_q, colSync_q;
  logic [15:0] divCnt_q;
  logic [1:0]  rowIdx_q;
  logic [15:0] hits_q, hitsNow;
  logic [3:0]  cand_q, cand_d;
  logic [7:0]  deb_q, deb_d;
  logic [3:0]  keyCode_q, keyCode_d;
  logic        keyValid_q, keyValid_d;
  logic        overrun_q, overrun_d;
  logic        rowEnd, frameEnd;
  logic [3:0]  colRev;
  logic [4:0]  hitCount;
  logic [3:0]  frameKey;
  logic        frameOne, frameNone;
  logic        debDone, accept;

  assign rowEnd   = (divCnt_q == 16'(SCAN_DIV - 1));
  assign frameEnd = rowEnd && (rowIdx_q == 2'd3);
  // col_in[3] is column 0, so reverse to make hit index = row*4 + col
  assign colRev   = {colSync_q[0], colSync_q[1], colSync_q[2], colSync_q[3]};

  always_comb begin
    hitsNow = hits_q;
    if (rowEnd) hitsNow[{rowIdx_q, 2'b00} +: 4] = colRev;
  end

  always_comb begin
    hitCount = 5'd0;
    frameKey = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hitsNow[i]) begin
        hitCount = hitCount + 5'd1;
        frameKey = 4'(i);
      end
    end
  end

  assign frameOne  = frameEnd && (hitCount == 5'd1);
  assign frameNone = frameEnd && (hitCount == 5'd0);
  assign debDone   = (deb_q >= 8'(DEBOUNCE_CNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colMeta_q <= 4'd0;
      colSync_q <= 4'd0;
      divCnt_q  <= 16'd0;
      rowIdx_q  <= 2'd0;
      hits_q    <= 16'd0;
    end else begin
      colMeta_q <= col_in;
      colSync_q <= colMeta_q;
      if (rowEnd) begin
        divCnt_q <= 16'd0;
        rowIdx_q <= rowIdx_q + 2'd1;
      end else begin
        divCnt_q <= divCnt_q + 16'd1;
      end
      if (frameEnd)    hits_q <= 16'd0;
      else if (rowEnd) hits_q <= hitsNow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      deb_q      <= 8'd0;
      keyCode_q  <= 4'd0;
      keyValid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      deb_q      <= deb_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Debounce FSM only advances on the end-of-frame cycle
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    deb_d   = deb_q;
    accept  = 1'b0;
    if (frameEnd) begin
      unique case (state_q)
        IDLE: begin
          if (frameOne) begin
            cand_d = frameKey;
            deb_d  = 8'd1;
            if (DEBOUNCE_CNT == 1) begin
              state_d = PRESSED;
              accept  = 1'b1;
            end else begin
              state_d = DB_PRESS;
            end
          end
        end
        DB_PRESS: begin
          if (frameOne && frameKey == cand_q) begin
            deb_d = deb_q + 8'd1;
            if (debDone) begin
              state_d = PRESSED;
              accept  = 1'b1;
            end
          end else if (frameOne) begin
            cand_d = frameKey;
            deb_d  = 8'd1;
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (!(frameOne && frameKey == cand_q)) begin
            deb_d   = 8'd1;
            state_d = (DEBOUNCE_CNT == 1) ? IDLE : DB_RELEASE;
          end
        end
        DB_RELEASE: begin
          if (frameNone) begin
            deb_d = deb_q + 8'd1;
            if (debDone) state_d = IDLE;
          end else if (frameOne && frameKey == cand_q) begin
            state_d = PRESSED;
          end else begin
            deb_d = 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A coincident ack frees the slot, so the new key loads without overrun
  always_comb begin
    keyCode_d  = keyCode_q;
    keyValid_d = keyValid_q;
    overrun_d  = overrun_q;
    if (key_ack && keyValid_q) begin
      keyValid_d = 1'b0;
      overrun_d  = 1'b0;
    end
    if (accept) begin
      if (!keyValid_q || key_ack) begin
        keyCode_d  = frameKey;
        keyValid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    row_out   = 4'b1000 >> rowIdx_q;
    key_held  = (state_q == PRESSED) || (state_q == DB_RELEASE);
    key_code  = keyCode_q;
    key_valid = keyValid_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Randomized scoreboard bench for keypad_scan_ctrl: a keypad model answers the
// row drive from a per-frame key mask, and a frame-level reference predicts accepts.
module tb_keypad_scan_ctrl;

  localparam int SD    = 4;
  localparam int DC    = 3;
  localparam int FRAME = 4 * SD;

  logic       clk;
  logic       rst_n;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       key_held;
  logic       overrun;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .col_in   (col_in),
    .row_out  (row_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ack  (key_ack),
    .key_held (key_held),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] curMask;
  int          checkCount;
  int          passCount;
  logic [3:0]  expQ[$];
  bit          autoAck;
  int          ackReq;
  int          ackServed;
  int          ackCnt;

  int          mHeld, mCand, mCnt, mRel, loadCnt, mCode;
  bit          ovrPending;
  int          ovrAck;
  bit          loadedNow;

  // Keypad model: a pressed key at (r,c) shorts row r to column c
  always_comb begin
    col_in = 4'd0;
    for (int r = 0; r < 4; r++)
      if (row_out == (4'b1000 >> r))
        for (int c = 0; c < 4; c++)
          col_in[3 - c] = curMask[r * 4 + c];
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic acceptKey(input int k);
    if (loadCnt != ackCnt) begin
      ovrPending = 1'b1;
      ovrAck     = ackCnt;
    end else begin
      expQ.push_back(4'(k));
      loadCnt++;
      mCode     = k;
      loadedNow = 1'b1;
    end
  endtask

  // Frame-level reference: classify the frame, then count runs of agreeing frames
  task automatic modelFrame(input logic [15:0] m);
    int n = $countones(m);
    int k = 0;
    bit one, none;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    one  = (n == 1);
    none = (n == 0);
    loadedNow = 1'b0;
    if (mHeld == 0) begin
      if (one) begin
        if (mCnt > 0 && k == mCand) mCnt++;
        else begin
          mCand = k;
          mCnt  = 1;
        end
        if (mCnt >= DC) begin
          mHeld = 1;
          mCnt  = 0;
          mRel  = 0;
          acceptKey(k);
        end
      end else begin
        mCnt = 0;
      end
    end else begin
      if (one && k == mCand) mRel = 0;
      else if (mRel == 0 || !none) mRel = 1;
      else mRel++;
      if (mRel >= DC) begin
        mHeld = 0;
        mRel  = 0;
        mCnt  = 0;
      end
    end
  endtask

  task automatic modelReset();
    mHeld = 0; mCand = 0; mCnt = 0; mRel = 0; mCode = 0;
    ovrPending = 1'b0;
    loadCnt = ackCnt;
  endtask

  // One whole scan frame with the given keys down, then frame-end checks
  task automatic applyStimulus(input logic [15:0] m);
    curMask = m;
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    modelFrame(m);
    checkOutput("key_held", int'(key_held), mHeld);
    checkOutput("overrun", int'(overrun), int'(ovrPending && ackCnt == ovrAck));
    if (loadedNow) checkOutput("valid_on_accept", int'(key_valid), 1);
  endtask

  // Consumer: acks automatically after a random delay, or on request
  initial begin
    key_ack   = 1'b0;
    ackCnt    = 0;
    ackServed = 0;
    forever begin
      @(negedge clk);
      if (rst_n && key_valid && (autoAck || ackReq != ackServed)) begin
        if (autoAck) repeat ($urandom_range(0, 3)) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack   = 1'b0;
        ackCnt++;
        ackServed = ackReq;
      end
    end
  end

  // Monitor: every new key_valid presentation must match the next expected code
  initial begin
    bit prevValid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && key_valid && !prevValid) begin
        if (expQ.size() == 0) checkOutput("unexpected_valid", int'(key_code), 16);
        else checkOutput("key_code", int'(key_code), int'(expQ.pop_front()));
      end
      prevValid = key_valid;
    end
  end

  initial begin
    int key, other, len;
    logic [15:0] m;
    checkCount = 0;
    passCount  = 0;
    autoAck    = 1'b1;
    ackReq     = 0;
    curMask    = 16'd0;
    rst_n      = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] row sequencing after reset");
    for (int k = 0; k < 2 * FRAME; k++) begin
      checkOutput("row_out", int'(row_out), int'(4'b1000 >> ((k / SD) % 4)));
      checkOutput("idle_outputs", int'({key_code, key_valid, key_held, overrun}), 0);
      @(negedge clk);
    end

    $display("[TB] press row1/col2 and hold");
    repeat (4) applyStimulus(16'd1 << 6);
    repeat (3) applyStimulus(16'd0);

    $display("[TB] bouncing press");
    applyStimulus(16'd1 << 11);
    applyStimulus(16'd1 << 11);
    applyStimulus(16'd0);
    repeat (3) applyStimulus(16'd1 << 11);
    repeat (3) applyStimulus(16'd0);

    $display("[TB] ghosting frames");
    repeat (4) applyStimulus(16'h0101);
    applyStimulus(16'd0);

    $display("[TB] overrun while unacknowledged");
    autoAck = 1'b0;
    repeat (3) applyStimulus(16'd1 << 0);
    repeat (3) applyStimulus(16'd0);
    repeat (3) applyStimulus(16'd1 << 5);
    checkOutput("ovr_valid", int'(key_valid), 1);
    checkOutput("ovr_code", int'(key_code), mCode);
    begin
      int ackBefore = ackCnt;
      ackReq++;
      applyStimulus(16'd1 << 5);
      checkOutput("ack_done", int'(ackCnt != ackBefore), 1);
      checkOutput("valid_after_ack", int'(key_valid), 0);
    end
    autoAck = 1'b1;
    repeat (3) applyStimulus(16'd0);

    $display("[TB] reset mid-debounce");
    repeat (2) applyStimulus(16'd1 << 9);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst_row_out", int'(row_out), 8);
    checkOutput("rst_outputs", int'({key_code, key_valid, key_held, overrun}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    repeat (3) applyStimulus(16'd1 << 9);
    repeat (3) applyStimulus(16'd0);

    $display("[TB] randomized presses");
    for (int seg = 0; seg < 40; seg++) begin
      key = $urandom_range(0, 15);
      len = $urandom_range(1, 6);
      for (int f = 0; f < len; f++) begin
        m = 16'd1 << key;
        if ($urandom_range(0, 9) == 0) begin
          other = (key + $urandom_range(1, 15)) % 16;
          m = m | (16'd1 << other);
        end
        applyStimulus(m);
      end
      len = $urandom_range(1, 5);
      for (int f = 0; f < len; f++) begin
        m = 16'd0;
        if ($urandom_range(0, 9) == 0) m = 16'd1 << $urandom_range(0, 15);
        applyStimulus(m);
      end
    end
    repeat (4) applyStimulus(16'd0);
    checkOutput("pending_expected", expQ.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
